lcd_text_formatter: RTL and testbench

- Upstream feeder of the LCD display driver: turns the processor's debug words (estado, pcAtual, progAtual) into a 32-character ASCII frame for the 16x2 panel.
- Snapshots the three words on a refresh tick, converts them to hex ASCII, and streams the characters one at a time over a valid/ready handshake with a 5-bit character address.
- The display driver consumes the stream and writes its character RAM / DDRAM.

---
 rtl/lcd_text_formatter_if.sv | 19 +
 rtl/lcd_text_formatter.sv | 142 ++++++++++++++
 tb/tb_lcd_text_formatter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_formatter_if.sv
// Character stream from the text formatter to the LCD display driver.
// Master presents one character plus its panel position; slave accepts with char_ready.
interface lcd_text_formatter_if;
   logic [7:0] char_data;
   logic [4:0] char_addr;
   logic       char_valid;
   logic       char_ready;
   logic       frame_done;

   modport master (
      output char_data, char_addr, char_valid, frame_done,
      input  char_ready
   );

   modport slave (
      input  char_data, char_addr, char_valid, frame_done,
      output char_ready
   );
endinterface

// File: rtl/lcd_text_formatter.sv
// Snapshots the processor debug words and streams them as a 32-char hex ASCII
// frame ("PC:xxxxxxxx E:xx" / "PG:xxxxxxxx     ") to the 16x2 LCD driver.
module lcd_text_formatter #(
   parameter int REFRESH_CYCLES = 2500000
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic [31:0]                 estado,
   input  logic [31:0]                 pcAtual,
   input  logic [31:0]                 progAtual,
   input  logic                        refresh_req,
   lcd_text_formatter_if.master        chr,
   output logic                        busy
);
   localparam int               CNT_W    = $clog2(REFRESH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             cnt_tc;
   logic [7:0]       est_q;
   logic [31:0]      pc_q, pg_q;
   logic [7:0]       data_q;
   logic [4:0]       addr_q;
   logic             valid_q, done_q, busy_q;
   logic [4:0]       addr_nx;
   logic [7:0]       char_nx;
   logic [7:0]       frame_w [32];
   logic             estado_unused;

   assign estado_unused = ^estado[31:8];

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Character at a panel position for a given set of debug words.
   function automatic logic [7:0] char_at(input logic [4:0]  addr,
                                          input logic [7:0]  e,
                                          input logic [31:0] pc,
                                          input logic [31:0] pg);
      logic [31:0] word;
      logic [3:0]  col;
      logic [7:0]  c;
      word = addr[4] ? pg : pc;
      col  = addr[3:0];
      c    = 8'h20;
      case (col)
         4'd0:    c = 8'h50;
         4'd1:    c = addr[4] ? 8'h47 : 8'h43;
         4'd2:    c = 8'h3A;
         4'd12:   if (!addr[4]) c = 8'h45;
         4'd13:   if (!addr[4]) c = 8'h3A;
         4'd14:   if (!addr[4]) c = hex_ascii(e[7:4]);
         4'd15:   if (!addr[4]) c = hex_ascii(e[3:0]);
         default: ;
      endcase
      for (int i = 0; i < 8; i++) begin
         if (col == 4'(i + 3)) c = hex_ascii(word[31 - 4*i -: 4]);
      end
      return c;
   endfunction

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_frame
         assign frame_w[gi] = char_at(5'(gi), est_q, pc_q, pg_q);
      end
   endgenerate

   // A request or tick always beats the IDLE clear so no refresh is ever lost.
   always_comb begin
      cnt_tc    = (cnt_q == CNT_LAST);
      cnt_d     = cnt_tc ? '0 : cnt_q + 1'b1;
      pending_d = pending_q;
      if (state_q == IDLE) pending_d = 1'b0;
      if (cnt_tc || refresh_req) pending_d = 1'b1;
      addr_nx   = addr_q + 5'd1;
      char_nx   = frame_w[addr_nx];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b1;
         est_q     <= '0;
         pc_q      <= '0;
         pg_q      <= '0;
         data_q    <= '0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pending_q) begin
                  state_q <= CAPTURE;
                  busy_q  <= 1'b1;
               end
            end
            CAPTURE: begin
               est_q   <= estado[7:0];
               pc_q    <= pcAtual;
               pg_q    <= progAtual;
               addr_q  <= 5'd0;
               data_q  <= char_at(5'd0, estado[7:0], pcAtual, progAtual);
               valid_q <= 1'b1;
               state_q <= SEND;
            end
            SEND: begin
               if (valid_q && chr.char_ready) begin
                  if (addr_q == 5'd31) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     addr_q  <= 5'd0;
                     data_q  <= 8'h00;
                     state_q <= IDLE;
                  end else begin
                     addr_q <= addr_nx;
                     data_q <= char_nx;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign chr.char_data  = data_q;
   assign chr.char_addr  = addr_q;
   assign chr.char_valid = valid_q;
   assign chr.frame_done = done_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_lcd_text_formatter.sv
// Self-checking bench for lcd_text_formatter: frames are collected off the
// character stream and compared with text built directly from the debug words.
module tb_lcd_text_formatter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] estado = '0;
   logic [31:0] pcAtual = '0;
   logic [31:0] progAtual = '0;
   logic        refresh_req = 1'b0;
   logic        busy;

   lcd_text_formatter_if bus ();

   lcd_text_formatter #(.REFRESH_CYCLES(64)) dut (
      .CLOCK_50    (clk),
      .reset       (reset),
      .estado      (estado),
      .pcAtual     (pcAtual),
      .progAtual   (progAtual),
      .refresh_req (refresh_req),
      .chr         (bus),
      .busy        (busy)
   );

   always #10 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  got [32];
   int          got_n;
   int          seq_err;
   int          start_cyc;
   int          c0;
   int          s1, s2, s3, s_c;
   logic        post_valid, post_done, post_done2, busy_start;

   // Reference text: "PC:" + 8 hex + " E:" + 2 hex, then "PG:" + 8 hex + 5 spaces.
   function automatic string exp_frame(input logic [7:0] e, input logic [31:0] pc,
                                       input logic [31:0] pg);
      string p, g, h;
      p = $sformatf("%08h", pc);
      g = $sformatf("%08h", pg);
      h = $sformatf("%02h", e);
      return {"PC:", p.toupper(), " E:", h.toupper(), "PG:", g.toupper(), "     "};
   endfunction

   function automatic string got_str();
      string s;
      s = "";
      for (int i = 0; i < 32; i++) s = $sformatf("%s%c", s, got[i]);
      return s;
   endfunction

   // Collects one frame; stall applies the ready pattern 1,0,0,1. Sequence
   // problems (wrong address, unstable held data, early done, timeout) add to seq_err.
   task automatic collect_frame(input bit stall, input int chg_at,
                                input logic [31:0] chg_pc, input bit pulse);
      int         k;
      int         budget;
      logic [7:0] hd;
      logic [4:0] ha;
      bit         held;
      k = 0; budget = 0; held = 0; hd = '0; ha = '0;
      got_n = 0; seq_err = 0; start_cyc = -1; busy_start = 1'b0;
      while (got_n < 32) begin
         @(negedge clk);
         refresh_req = 1'b0;
         budget++;
         if (budget > 3000) begin
            seq_err++;
            break;
         end
         if (bus.char_valid) begin
            if (k == 0) begin
               start_cyc  = cyc;
               busy_start = busy;
            end
            if (bus.frame_done) seq_err++;
            if (held && (bus.char_data !== hd || bus.char_addr !== ha)) seq_err++;
            if (pulse && (k == 4 || k == 10 || k == 20)) refresh_req = 1'b1;
            if (got_n == chg_at) pcAtual = chg_pc;
            if (stall && (k % 4 == 1 || k % 4 == 2)) begin
               bus.char_ready = 1'b0;
               held = 1;
               hd = bus.char_data;
               ha = bus.char_addr;
            end else begin
               bus.char_ready = 1'b1;
               held = 0;
               if (bus.char_addr !== 5'(got_n)) seq_err++;
               got[got_n] = bus.char_data;
               got_n++;
            end
            k++;
         end else begin
            bus.char_ready = 1'b1;
            if (k != 0) seq_err++;
         end
      end
      @(negedge clk);
      refresh_req = 1'b0;
      post_valid = bus.char_valid;
      post_done  = bus.frame_done;
      @(negedge clk);
      post_done2 = bus.frame_done;
      $display("frame start=%0d stall=%0d text=\"%s\" seq_err=%0d", start_cyc, stall, got_str(), seq_err);
   endtask

   task automatic test_reset();
      estado = 32'h0000_0005; pcAtual = 32'h0040_001C; progAtual = 32'h8C22_0004;
      bus.char_ready = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.char_valid); end
      n_checks++; if (bus.char_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h required 00", bus.char_data); end
      n_checks++; if (bus.char_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d required 0", bus.char_addr); end
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", bus.frame_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      reset = 1'b0;
      c0 = cyc;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL capture_busy: got %b required 1", busy); end
      n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL capture_valid: got %b required 0", bus.char_valid); end
   endtask

   task automatic test_first_frame();
      collect_frame(0, -1, '0, 0);
      n_checks++; if (start_cyc !== c0 + 2) begin n_fail++; $display("FAIL first_latency: got %0d required %0d", start_cyc - c0, 2); end
      n_checks++; if (got_str() != "PC:0040001C E:05PG:8C220004     ") begin n_fail++; $display("FAIL first_text: got \"%s\" required \"PC:0040001C E:05PG:8C220004     \"", got_str()); end
      n_checks++; if (seq_err !== 0) begin n_fail++; $display("FAIL first_sequence: got %0d errors required 0", seq_err); end
      n_checks++; if (busy_start !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b required 1", busy_start); end
      n_checks++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_drop: got %b required 0", post_valid); end
      n_checks++; if (post_done !== 1'b1) begin n_fail++; $display("FAIL first_done_pulse: got %b required 1", post_done); end
      n_checks++; if (post_done2 !== 1'b0) begin n_fail++; $display("FAIL first_done_width: got %b required 0", post_done2); end
   endtask

   task automatic test_backpressure();
      collect_frame(1, -1, '0, 0);
      n_checks++; if (got_str() != exp_frame(estado[7:0], pcAtual, progAtual)) begin n_fail++; $display("FAIL stall_text: got \"%s\" required \"%s\"", got_str(), exp_frame(estado[7:0], pcAtual, progAtual)); end
      n_checks++; if (seq_err !== 0) begin n_fail++; $display("FAIL stall_sequence: got %0d errors required 0", seq_err); end
      n_checks++; if (post_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b required 1", post_done); end
   endtask

   task automatic test_snapshot();
      logic [31:0] old_pc;
      old_pc = pcAtual;
      collect_frame(0, 5, 32'hFFFF_FFFF, 0);
      n_checks++; if (got_str() != exp_frame(estado[7:0], old_pc, progAtual)) begin n_fail++; $display("FAIL snapshot_old: got \"%s\" required \"%s\"", got_str(), exp_frame(estado[7:0], old_pc, progAtual)); end
      collect_frame(0, -1, '0, 0);
      n_checks++; if (got_str() != exp_frame(estado[7:0], 32'hFFFF_FFFF, progAtual)) begin n_fail++; $display("FAIL snapshot_new: got \"%s\" required \"%s\"", got_str(), exp_frame(estado[7:0], 32'hFFFF_FFFF, progAtual)); end
   endtask

   task automatic test_hex_boundary();
      logic [63:0] pc_chars;
      logic [15:0] e_chars;
      pcAtual = 32'h9A0F_A09F; estado = 32'hABCD_12FF;
      collect_frame(0, -1, '0, 0);
      pc_chars = {got[3], got[4], got[5], got[6], got[7], got[8], got[9], got[10]};
      e_chars  = {got[14], got[15]};
      n_checks++; if (pc_chars !== 64'h3941_3046_4130_3946) begin n_fail++; $display("FAIL hex_pc_digits: got %h required 3941304641303946", pc_chars); end
      n_checks++; if (e_chars !== 16'h4646) begin n_fail++; $display("FAIL hex_estado_digits: got %h required 4646", e_chars); end
      n_checks++; if (got_str() != exp_frame(8'hFF, pcAtual, progAtual)) begin n_fail++; $display("FAIL hex_text: got \"%s\" required \"%s\"", got_str(), exp_frame(8'hFF, pcAtual, progAtual)); end
   endtask

   task automatic test_random();
      bit stall;
      for (int it = 0; it < 6; it++) begin
         pcAtual = $urandom; progAtual = $urandom; estado = $urandom;
         stall = 1'($urandom_range(0, 1));
         collect_frame(stall, -1, '0, 0);
         n_checks++; if (got_str() != exp_frame(estado[7:0], pcAtual, progAtual)) begin n_fail++; $display("FAIL random_text[%0d]: got \"%s\" required \"%s\"", it, got_str(), exp_frame(estado[7:0], pcAtual, progAtual)); end
         n_checks++; if (seq_err !== 0) begin n_fail++; $display("FAIL random_sequence[%0d]: got %0d errors required 0", it, seq_err); end
      end
   endtask

   task automatic test_mid_reset();
      bit found;
      found = 0;
      for (int b = 0; b < 400 && !found; b++) begin
         @(negedge clk);
         bus.char_ready = 1'b1;
         if (bus.char_valid && bus.char_addr == 5'd12) found = 1;
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_addr12: got %b required 1", found); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b required 0", bus.char_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", busy); end
      @(negedge clk);
      reset = 1'b0;
      c0 = cyc;
      collect_frame(0, -1, '0, 0);
      n_checks++; if (start_cyc !== c0 + 2) begin n_fail++; $display("FAIL midreset_restart: got %0d required %0d", start_cyc - c0, 2); end
      n_checks++; if (seq_err !== 0) begin n_fail++; $display("FAIL midreset_sequence: got %0d errors required 0", seq_err); end
      n_checks++; if (got_str() != exp_frame(estado[7:0], pcAtual, progAtual)) begin n_fail++; $display("FAIL midreset_text: got \"%s\" required \"%s\"", got_str(), exp_frame(estado[7:0], pcAtual, progAtual)); end
   endtask

   task automatic test_auto_refresh();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      c0 = cyc;
      collect_frame(0, -1, '0, 0); s1 = start_cyc;
      collect_frame(0, -1, '0, 0); s2 = start_cyc;
      collect_frame(0, -1, '0, 0); s3 = start_cyc;
      n_checks++; if (s1 !== c0 + 2) begin n_fail++; $display("FAIL auto_first: got %0d required %0d", s1 - c0, 2); end
      n_checks++; if (s2 - s1 !== 64) begin n_fail++; $display("FAIL auto_period1: got %0d required 64", s2 - s1); end
      n_checks++; if (s3 - s2 !== 64) begin n_fail++; $display("FAIL auto_period2: got %0d required 64", s3 - s2); end
   endtask

   task automatic test_back_to_back();
      int n_after;
      collect_frame(0, -1, '0, 1);
      s_c = start_cyc;
      n_checks++; if (s_c - s3 !== 64) begin n_fail++; $display("FAIL req_frame_period: got %0d required 64", s_c - s3); end
      n_after = 0;
      for (int i = 0; i < 4; i++) begin
         collect_frame(0, -1, '0, 0);
         if (i == 0) begin
            n_checks++; if (start_cyc - s_c !== 34) begin n_fail++; $display("FAIL b2b_gap: got %0d required 34", start_cyc - s_c); end
            n_checks++; if (got_str() != exp_frame(estado[7:0], pcAtual, progAtual)) begin n_fail++; $display("FAIL b2b_text: got \"%s\" required \"%s\"", got_str(), exp_frame(estado[7:0], pcAtual, progAtual)); end
         end
         if (start_cyc < s_c + 120) n_after++;
         else break;
      end
      n_checks++; if (n_after !== 2) begin n_fail++; $display("FAIL req_collapse: got %0d frames after requested frame required 2", n_after); end
   endtask

   initial begin
      bus.char_ready = 1'b1;
      test_reset();
      test_first_frame();
      test_backpressure();
      test_snapshot();
      test_hex_boundary();
      test_random();
      test_mid_reset();
      test_auto_refresh();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1, "watchdog");
   end
endmodule
